alarme: RTL
===========

# alarme

Alarm unit for the digital clock. It sits downstream of the hour/minute/second counters and consumes their BCD digits. It holds a user-set alarm time (HH:MM), compares it against the running time and drives a buzzer, with arm/disarm, edit and snooze functions. Its alarm-time digits feed the same seven-segment decoders the clock uses while editing.

## Interface
Parameters:
- SNOOZE_S, 300: snooze duration in seconds (1..511).
- RING_S, 60: maximum ring duration in seconds before auto-stop (1..511).

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- tick_1hz  in  1  one-clk-wide enable pulse, once per second, synchronous to clk.
- h_msd / h_lsd  in  2 / 4  current hour BCD (00..23).
- m_msd / m_lsd  in  3 / 4  current minute BCD (00..59).
- s_msd / s_lsd  in  3 / 4  current second BCD (00..59).
- btn_set, btn_hr, btn_min, btn_arm, btn_snooze  in  1 each  debounced single-cycle button pulses.
- al_h_msd / al_h_lsd  out  2 / 4  alarm hour BCD.
- al_m_msd / al_m_lsd  out  3 / 4  alarm minute BCD.
- buzzer  out  1  high while ringing.
- armed  out  1  high in ARMED, RING and SNOOZE.
- editing  out  1  high in EDIT.
- snoozing  out  1  high in SNOOZE.

## Operation
- States: OFF, ARMED, EDIT, RING, SNOOZE.
- Reset: state OFF, alarm 00:00, buzzer/armed/editing/snoozing 0, counters 0, match_q 0.
- match = (h,m digits equal alarm digits) AND s_msd=0 AND s_lsd=0. match_q is the registered copy, updated every cycle in every state. trigger = match AND NOT match_q.
- Button priority within one cycle: btn_arm > btn_set > btn_snooze. btn_hr/btn_min act only in EDIT and are independent of each other.
- OFF: btn_arm -> ARMED. btn_set -> EDIT. trigger is ignored.
- ARMED: btn_arm -> OFF. btn_set -> EDIT. trigger -> RING, ring counter loaded with RING_S.
- EDIT:
  - btn_hr increments the alarm hour, wrapping 23 -> 00.
  - btn_min increments the alarm minute, wrapping 59 -> 00, with no carry into the hour.
  - Both pulses in the same cycle apply both increments.
  - btn_set -> ARMED (leaving edit always arms). btn_arm, btn_snooze and trigger are ignored.
- RING:
  - btn_arm -> OFF (dismiss).
  - btn_snooze -> SNOOZE, snooze counter loaded with SNOOZE_S.
  - On each tick_1hz the ring counter decrements; the tick that takes it to 0 -> ARMED (auto-stop, stays armed for the next day).
  - btn_set and trigger are ignored.
- SNOOZE:
  - btn_arm -> OFF.
  - On each tick_1hz the snooze counter decrements; the tick that takes it to 0 -> RING, ring counter reloaded with RING_S.
  - btn_snooze, btn_set and trigger are ignored.
- Counters are 9 bits. BCD arithmetic is per digit; inputs are not range-checked.
- Arming during the matching second does not ring, because match_q is already 1 and no edge occurs.

## Timing
- All outputs are registered. An input event in cycle N is visible on outputs in cycle N+1.
- Trigger: the first cycle the time inputs show HH:MM:00 equal to the alarm -> buzzer=1 the next cycle.
- A tick_1hz coinciding with the trigger cycle does not decrement the freshly loaded ring counter.
- Ring lasts exactly RING_S tick_1hz pulses after entry, then buzzer=0 the cycle after the last tick.
- A snooze button in the same cycle as the final ring tick: btn_snooze wins -> SNOOZE.
- btn_arm in the same cycle as a tick that would expire a counter: btn_arm wins -> OFF.
- rst has priority over everything in any state, including mid-ring and mid-edit: the next cycle shows reset values.

## Test plan
- Bench uses SNOOZE_S=3, RING_S=4. Reset, then btn_set, btn_hr x7, btn_min x30, btn_set -> alarm 07:30, editing 1 then 0, armed=1.
- Alarm 07:30, armed. Drive time 07:29:59 -> 07:30:00 -> buzzer=1 one cycle later. After 4 ticks: buzzer=0, state ARMED. Holding 07:30:00 afterwards does not retrigger.
- Ringing. btn_snooze -> snoozing=1, buzzer=0. After 3 ticks: buzzer=1. Then btn_arm -> buzzer=0, armed=0.
- Edit wrap: alarm 23:59. btn_hr and btn_min in the same cycle -> 00:00, hour not carried from the minute wrap.
- State OFF, time 07:30:00 equal to alarm. btn_arm -> armed=1, buzzer stays 0 for the rest of that second.
- rst asserted mid-ring and mid-snooze -> next cycle buzzer=0, armed=0, alarm 00:00, state OFF.

Source files
------------

// File: rtl/alarme.sv
// Alarm unit: stores an HH:MM alarm in BCD, compares it with the running time
// and sequences ring, snooze, arm and edit behaviour for the buzzer.
module alarme #(
   parameter int SNOOZE_S = 300,
   parameter int RING_S   = 60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1hz,
   input  logic [1:0] h_msd,
   input  logic [3:0] h_lsd,
   input  logic [2:0] m_msd,
   input  logic [3:0] m_lsd,
   input  logic [2:0] s_msd,
   input  logic [3:0] s_lsd,
   input  logic       btn_set,
   input  logic       btn_hr,
   input  logic       btn_min,
   input  logic       btn_arm,
   input  logic       btn_snooze,
   output logic [1:0] al_h_msd,
   output logic [3:0] al_h_lsd,
   output logic [2:0] al_m_msd,
   output logic [3:0] al_m_lsd,
   output logic       buzzer,
   output logic       armed,
   output logic       editing,
   output logic       snoozing
);

   typedef enum logic [2:0] {
      S_OFF, S_ARMED, S_EDIT, S_RING, S_SNOOZE
   } state_t;

   localparam logic [8:0] RING_L   = 9'(RING_S);
   localparam logic [8:0] SNOOZE_L = 9'(SNOOZE_S);

   state_t     state, state_n;
   logic [8:0] ring_cnt, ring_n;
   logic [8:0] snz_cnt, snz_n;
   logic       match, match_q, trigger;
   logic [1:0] h_msd_n, h_msd_i;
   logic [3:0] h_lsd_n, h_lsd_i;
   logic [2:0] m_msd_n, m_msd_i;
   logic [3:0] m_lsd_n, m_lsd_i;

   assign match = (h_msd == al_h_msd) && (h_lsd == al_h_lsd) &&
                  (m_msd == al_m_msd) && (m_lsd == al_m_lsd) &&
                  (s_msd == 3'd0) && (s_lsd == 4'd0);
   assign trigger = match && !match_q;

   // Per-digit BCD increments; minute wrap never carries into the hour
   always_comb begin
      h_msd_i = al_h_msd;
      h_lsd_i = 4'(al_h_lsd + 4'd1);
      if (al_h_msd == 2'd2 && al_h_lsd == 4'd3) begin
         h_msd_i = 2'd0;
         h_lsd_i = 4'd0;
      end else if (al_h_lsd == 4'd9) begin
         h_msd_i = 2'(al_h_msd + 2'd1);
         h_lsd_i = 4'd0;
      end
      m_msd_i = al_m_msd;
      m_lsd_i = 4'(al_m_lsd + 4'd1);
      if (al_m_lsd == 4'd9) begin
         m_lsd_i = 4'd0;
         m_msd_i = (al_m_msd == 3'd5) ? 3'd0 : 3'(al_m_msd + 3'd1);
      end
   end

   always_comb begin
      state_n = state;
      ring_n  = ring_cnt;
      snz_n   = snz_cnt;
      h_msd_n = al_h_msd;
      h_lsd_n = al_h_lsd;
      m_msd_n = al_m_msd;
      m_lsd_n = al_m_lsd;
      unique case (state)
         S_OFF: begin
            if (btn_arm)      state_n = S_ARMED;
            else if (btn_set) state_n = S_EDIT;
         end
         S_ARMED: begin
            if (btn_arm)      state_n = S_OFF;
            else if (btn_set) state_n = S_EDIT;
            else if (trigger) begin
               state_n = S_RING;
               ring_n  = RING_L;
            end
         end
         S_EDIT: begin
            if (btn_hr) begin
               h_msd_n = h_msd_i;
               h_lsd_n = h_lsd_i;
            end
            if (btn_min) begin
               m_msd_n = m_msd_i;
               m_lsd_n = m_lsd_i;
            end
            if (btn_set) state_n = S_ARMED;
         end
         S_RING: begin
            if (btn_arm) state_n = S_OFF;
            else if (btn_snooze) begin
               state_n = S_SNOOZE;
               snz_n   = SNOOZE_L;
            end else if (tick_1hz) begin
               if (ring_cnt <= 9'd1) begin
                  state_n = S_ARMED;
                  ring_n  = 9'd0;
               end else begin
                  ring_n = ring_cnt - 9'd1;
               end
            end
         end
         S_SNOOZE: begin
            if (btn_arm) state_n = S_OFF;
            else if (tick_1hz) begin
               if (snz_cnt <= 9'd1) begin
                  state_n = S_RING;
                  ring_n  = RING_L;
                  snz_n   = 9'd0;
               end else begin
                  snz_n = snz_cnt - 9'd1;
               end
            end
         end
         default: state_n = S_OFF;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_OFF;
         ring_cnt <= 9'd0;
         snz_cnt  <= 9'd0;
         match_q  <= 1'b0;
         al_h_msd <= 2'd0;
         al_h_lsd <= 4'd0;
         al_m_msd <= 3'd0;
         al_m_lsd <= 4'd0;
         buzzer   <= 1'b0;
         armed    <= 1'b0;
         editing  <= 1'b0;
         snoozing <= 1'b0;
      end else begin
         state    <= state_n;
         ring_cnt <= ring_n;
         snz_cnt  <= snz_n;
         match_q  <= match;
         al_h_msd <= h_msd_n;
         al_h_lsd <= h_lsd_n;
         al_m_msd <= m_msd_n;
         al_m_lsd <= m_lsd_n;
         buzzer   <= (state_n == S_RING);
         armed    <= (state_n == S_ARMED) || (state_n == S_RING) ||
                     (state_n == S_SNOOZE);
         editing  <= (state_n == S_EDIT);
         snoozing <= (state_n == S_SNOOZE);
      end
   end

endmodule
